// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: decodes a UART opcode byte, grants one engine and muxes its TX onto uart_tx.
// Optional NAK_REPLY_EN: an unknown opcode is answered with a NAK byte (8'h15) before draining.
module cmd_dispatcher #(
    parameter int unsigned          NUM_ENG        = 6,
    parameter logic [8*NUM_ENG-1:0] OPCODES        = 48'h72_71_24_23_22_21,
    parameter logic [31:0]          TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic                   clk_50mhz,
    input  logic                   reset,
    input  logic                   rx_ready,
    input  logic [7:0]             rx_data,
    input  logic                   tx_active,
    input  logic [NUM_ENG-1:0]     eng_done,
    input  logic [8*NUM_ENG-1:0]   eng_tx_data,
    input  logic [NUM_ENG-1:0]     eng_tx_start,
    output logic [NUM_ENG-1:0]     eng_activate,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic                   busy,
    output logic [7:0]             state_code,
    output logic                   err_unknown,
    output logic                   err_timeout
);

    localparam int unsigned IDX_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int unsigned WD_W   = 32;
    localparam logic [7:0]  NAK_BYTE = 8'h15;

`ifdef NAK_REPLY_EN
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_NAK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;
`endif

    state_t             state, state_d;
    logic [IDX_W-1:0]   gnt_idx, gnt_idx_d;
    logic [WD_W-1:0]    wd_cnt, wd_cnt_d, wd_inc;
    logic               wd_hit;
    logic [NUM_ENG-1:0] act_d;
    logic [7:0]         txd_d, code_d;
    logic               txs_d, busy_d, eu_d, et_d;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [7:0]         hit_code;
    logic [7:0]         sel_data;
    logic               sel_start, sel_done;

    // Opcode decode: descending scan so the lowest matching index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_code = '0;
        for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
            if (OPCODES[8*i +: 8] == rx_data) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_code = OPCODES[8*i +: 8];
            end
        end
    end

    // Granted-engine mux; other engines never reach uart_tx.
    always_comb begin
        sel_data  = '0;
        sel_start = 1'b0;
        sel_done  = 1'b0;
        for (int i = 0; i < int'(NUM_ENG); i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_data  = eng_tx_data[8*i +: 8];
                sel_start = eng_tx_start[i];
                sel_done  = eng_done[i];
            end
        end
    end

    assign wd_inc = (wd_cnt == '1) ? wd_cnt : wd_cnt + 32'd1;
    assign wd_hit = (TIMEOUT_CYCLES != 32'd0) && (wd_inc >= TIMEOUT_CYCLES);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        gnt_idx_d = gnt_idx;
        wd_cnt_d  = wd_cnt;
        act_d     = eng_activate;
        txd_d     = tx_data;
        txs_d     = 1'b0;
        busy_d    = busy;
        code_d    = state_code;
        eu_d      = 1'b0;
        et_d      = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_ready) begin
                    if (hit) begin
                        state_d   = S_ACTIVE;
                        gnt_idx_d = hit_idx;
                        wd_cnt_d  = '0;
                        act_d     = NUM_ENG'(1) << hit_idx;
                        busy_d    = 1'b1;
                        code_d    = hit_code;
                    end else begin
                        eu_d = 1'b1;
`ifdef NAK_REPLY_EN
                        state_d = S_NAK;
                        busy_d  = 1'b1;
                        code_d  = 8'hFF;
`endif
                    end
                end
            end
            S_ACTIVE: begin
                wd_cnt_d = wd_inc;
                txd_d    = sel_data;
                txs_d    = sel_start;
                if (sel_done || wd_hit) begin
                    state_d = S_DRAIN;
                    act_d   = '0;
                    txs_d   = 1'b0;
                    code_d  = 8'h01;
                    et_d    = !sel_done;
                end
            end
            S_DRAIN: begin
                if (!rx_ready && !tx_active) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    code_d  = 8'h00;
                end
            end
`ifdef NAK_REPLY_EN
            S_NAK: begin
                if (!tx_active) begin
                    state_d = S_DRAIN;
                    txd_d   = NAK_BYTE;
                    txs_d   = 1'b1;
                    code_d  = 8'h01;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            state        <= S_IDLE;
            gnt_idx      <= '0;
            wd_cnt       <= '0;
            eng_activate <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            busy         <= 1'b0;
            state_code   <= 8'h00;
            err_unknown  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_d;
            gnt_idx      <= gnt_idx_d;
            wd_cnt       <= wd_cnt_d;
            eng_activate <= act_d;
            tx_data      <= txd_d;
            tx_start     <= txs_d;
            busy         <= busy_d;
            state_code   <= code_d;
            err_unknown  <= eu_d;
            err_timeout  <= et_d;
        end
    end

    a_onehot_act: assert property (@(posedge clk_50mhz) disable iff (!reset) $onehot0(eng_activate));

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Testbench for cmd_dispatcher: directed scenarios plus random traffic against a transaction-level model.
module tb_cmd_dispatcher;

    localparam int unsigned NE  = 6;
    localparam logic [47:0] OPC = 48'h72_71_24_23_22_21;
    localparam int          TO  = 100;
    localparam int M_IDLE = 0, M_ACT = 1, M_DRAIN = 2, M_NAK = 3;

    logic            clk_50mhz = 1'b0;
    logic            reset = 1'b0;
    logic            rx_ready = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            tx_active = 1'b0;
    logic [NE-1:0]   eng_done = '0;
    logic [8*NE-1:0] eng_tx_data = '0;
    logic [NE-1:0]   eng_tx_start = '0;
    logic [NE-1:0]   eng_activate;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            busy;
    logic [7:0]      state_code;
    logic            err_unknown;
    logic            err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_mode = M_IDLE;
    int         m_eng = 0;
    int         m_age = 0;
    int         m_k = 0;
    logic [7:0] m_txd = 8'h00;
    logic       m_txs = 1'b0;
    logic       m_eu = 1'b0;
    logic       m_et = 1'b0;

    cmd_dispatcher #(
        .NUM_ENG(NE),
        .OPCODES(OPC),
        .TIMEOUT_CYCLES(32'(TO))
    ) dut (
        .clk_50mhz(clk_50mhz),
        .reset(reset),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .tx_active(tx_active),
        .eng_done(eng_done),
        .eng_tx_data(eng_tx_data),
        .eng_tx_start(eng_tx_start),
        .eng_activate(eng_activate),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .busy(busy),
        .state_code(state_code),
        .err_unknown(err_unknown),
        .err_timeout(err_timeout)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] opc(input int i);
        logic [47:0] t;
        t = OPC;
        return t[8*i +: 8];
    endfunction

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < int'(NE); i++)
            if (opc(i) == b) return i;
        return -1;
    endfunction

    function automatic logic [NE-1:0] exp_act();
        return (m_mode == M_ACT) ? (NE'(1) << m_eng) : '0;
    endfunction

    function automatic logic [7:0] exp_code();
        case (m_mode)
            M_ACT:   return opc(m_eng);
            M_DRAIN: return 8'h01;
            M_NAK:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs the DUT is about to sample.
    task automatic model_step();
        if (!reset) begin
            m_mode = M_IDLE; m_age = 0; m_txd = 8'h00;
            m_txs = 1'b0; m_eu = 1'b0; m_et = 1'b0;
            return;
        end
        m_eu = 1'b0; m_et = 1'b0; m_txs = 1'b0;
        case (m_mode)
            M_IDLE: if (rx_ready) begin
                m_k = lookup(rx_data);
                if (m_k >= 0) begin
                    m_mode = M_ACT; m_eng = m_k; m_age = 0;
                end else begin
                    m_eu = 1'b1;
`ifdef NAK_REPLY_EN
                    m_mode = M_NAK;
`endif
                end
            end
            M_ACT: begin
                m_age++;
                m_txd = eng_tx_data[8*m_eng +: 8];
                m_txs = eng_tx_start[m_eng];
                if (eng_done[m_eng]) begin
                    m_mode = M_DRAIN; m_txs = 1'b0;
                end else if (TO != 0 && m_age >= TO) begin
                    m_mode = M_DRAIN; m_txs = 1'b0; m_et = 1'b1;
                end
            end
            M_DRAIN: if (!rx_ready && !tx_active) m_mode = M_IDLE;
            M_NAK: if (!tx_active) begin
                m_txd = 8'h15; m_txs = 1'b1; m_mode = M_DRAIN;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // One clock: model follows the edge, then all outputs are compared on the falling edge.
    task automatic tick();
        model_step();
        @(negedge clk_50mhz);
        check("eng_activate", 64'(eng_activate), 64'(exp_act()));
        check("tx_data", 64'(tx_data), 64'(m_txd));
        check("tx_start", 64'(tx_start), 64'(m_txs));
        check("busy", 64'(busy), 64'(m_mode != M_IDLE));
        check("state_code", 64'(state_code), 64'(exp_code()));
        check("err_unknown", 64'(err_unknown), 64'(m_eu));
        check("err_timeout", 64'(err_timeout), 64'(m_et));
    endtask

    task automatic send(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic finish_engine(input int e);
        eng_done = NE'(1) << e;
        tick();
        eng_done = '0;
        tick();
    endtask

    initial begin
        int n;
        @(negedge clk_50mhz);
        reset = 1'b0;
        tick();
        tick();
        check("rst_code", 64'(state_code), 64'h00);
        check("rst_busy", 64'(busy), 64'h0);
        reset = 1'b1;
        tick();

        // Basic grant, done, drain to idle
        send(8'h23);
        check("t1_act", 64'(eng_activate), 64'b000100);
        check("t1_code", 64'(state_code), 64'h23);
        check("t1_busy", 64'(busy), 64'h1);
        tick();
        tick();
        eng_done = 6'b000100;
        tick();
        check("t1_drop", 64'(eng_activate), 64'h0);
        eng_done = '0;
        tick();
        check("t1_idle", 64'(state_code), 64'h00);

        // TX mux isolates non-granted engines
        send(8'h71);
        eng_tx_data = '0;
        eng_tx_data[39:32] = 8'h41;
        eng_tx_data[7:0]   = 8'h55;
        eng_tx_start = 6'b010001;
        tick();
        check("t2_txd", 64'(tx_data), 64'h41);
        check("t2_txs", 64'(tx_start), 64'h1);
        repeat (4) begin
            tick();
            check("t2_no55", 64'(tx_data == 8'h55), 64'h0);
        end
        eng_tx_start = '0;
        finish_engine(4);

        // Unknown opcode
        send(8'h99);
        check("t3_eu", 64'(err_unknown), 64'h1);
        check("t3_act", 64'(eng_activate), 64'h0);
        tick();
        check("t3_eu_pulse", 64'(err_unknown), 64'h0);
        tick();
        tick();

        // Watchdog abort after TO active cycles
        send(8'h21);
        n = 0;
        while (eng_activate != '0 && n < 200) begin
            tick();
            n++;
        end
        check("t4_latency", 64'(n), 64'(TO));
        check("t4_err_to", 64'(err_timeout), 64'h1);
        tick();
        check("t4_err_pulse", 64'(err_timeout), 64'h0);
        tick();

        // Done on the timeout edge wins
        send(8'h21);
        repeat (TO - 1) tick();
        eng_done = 6'b000001;
        tick();
        check("t4b_drop", 64'(eng_activate), 64'h0);
        check("t4b_no_to", 64'(err_timeout), 64'h0);
        eng_done = '0;
        tick();
        tick();

        // DRAIN holds while TX busy and ignores rx strobes
        send(8'h22);
        tick();
        tx_active = 1'b1;
        eng_done = 6'b000010;
        tick();
        eng_done = '0;
        for (int i = 0; i < 20; i++) begin
            rx_ready = (i % 2 == 0);
            rx_data  = 8'h22;
            tick();
            check("t5_code", 64'(state_code), 64'h01);
            check("t5_act", 64'(eng_activate), 64'h0);
        end
        rx_ready = 1'b0;
        tx_active = 1'b0;
        tick();
        check("t5_idle", 64'(state_code), 64'h00);
        check("t5_busy", 64'(busy), 64'h0);

        // Reset in the middle of an ACTIVE grant
        send(8'h24);
        check("t6_act", 64'(eng_activate), 64'b001000);
        eng_tx_start = 6'b001000;
        tick();
        reset = 1'b0;
        tick();
        check("t6_act_rst", 64'(eng_activate), 64'h0);
        check("t6_code_rst", 64'(state_code), 64'h00);
        check("t6_txs_rst", 64'(tx_start), 64'h0);
        reset = 1'b1;
        eng_tx_start = '0;
        send(8'h24);
        check("t6_regrant", 64'(eng_activate), 64'b001000);
        check("t6_code", 64'(state_code), 64'h24);
        finish_engine(3);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            rx_ready = ($urandom_range(0, 3) == 0);
            rx_data = ($urandom_range(0, 9) < 7) ? opc(int'($urandom_range(0, NE - 1)))
                                                  : 8'($urandom);
            tx_active = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < int'(NE); b++)
                eng_done[b] = ($urandom_range(0, 49) == 0);
            eng_tx_data = 48'({$urandom, $urandom});
            eng_tx_start = NE'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL sim_timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
